rob: RTL and testbench
======================

Name: rob

Overview:
- Reorder buffer: allocates 5-bit tags to dispatched instructions and records their results from the CDB.
- Retires instructions in program order.
- Sits directly upstream of the register status table. It drives the table's tag-write data (dispatch_tag) and its commit tag-clear pair (commit_tag / commit_valid → RB_tag_rst / RB_valid_rst).
- Also serves operand lookups by tag for issue.

Parameters:
DEPTH, 32, number of entries; fixed at 2^5 to match the 5-bit RST tag width
DATA_W, 32, result data width

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
dispatch_valid  input  1  request to allocate an entry
dispatch_dest  input  5  architectural destination register
dispatch_wr  input  1  instruction writes a register
dispatch_tag  output  5  tag that the next accepted dispatch receives (= tail)
rob_full  output  1  count == DEPTH
count  output  6  occupied entries, 0..32
cdb_valid  input  1  result broadcast valid
cdb_tag  input  5  tag of broadcast result
cdb_data  input  DATA_W  broadcast result
Rs_tag_rob  input  5  operand-s lookup tag
Rs_ready_rob  output  1  result for Rs_tag_rob available
Rs_data_rob  output  DATA_W  that result
Rt_tag_rob  input  5  operand-t lookup tag
Rt_ready_rob  output  1  result for Rt_tag_rob available
Rt_data_rob  output  DATA_W  that result
commit_valid  output  1  head entry retiring this cycle (to RST RB_valid_rst)
commit_tag  output  5  head tag (to RST RB_tag_rst)
commit_dest  output  5  architectural destination of head
commit_wr  output  1  head writes register file
commit_data  output  DATA_W  head result
flush  input  1  synchronous squash of all entries

Behaviour:
Entry state:
- Each entry holds: valid, ready, wr, dest[4:0], data[DATA_W-1:0].
- head and tail are 5-bit pointers that wrap 31→0 naturally. count is 6-bit.

Reset:
- Async; all entries are cleared to zero.
- head = tail = count = 0.
- All outputs read 0: dispatch_tag 0, rob_full 0, count 0, commit_* 0, Rs/Rt ready 0, data 0.
- Reset mid-operation abandons all in-flight entries; no commit is emitted.

Dispatch:
- Accepted iff dispatch_valid && !rob_full, where rob_full is derived from the registered count.
- On accept at the edge: entry[tail] ← {valid=1, ready=0, wr=dispatch_wr, dest=dispatch_dest}; tail += 1.
- dispatch_tag is combinational = tail.
- A rejected dispatch changes no state.

CDB writeback:
- If cdb_valid && entry[cdb_tag].valid: set ready=1 and data=cdb_data at the edge.
- A broadcast to an invalid entry is ignored.
- A broadcast to the entry being allocated in the same cycle is ignored; the entry was invalid before the edge.

Commit:
- commit_valid is combinational = entry[head].valid && entry[head].ready && !flush.
- commit_tag = head; the other commit_* fields come from entry[head]. All commit_* outputs are 0 when the head entry is invalid.
- When commit_valid is high: entry[head].valid ← 0 and head += 1 at the same edge.
- At most one commit per cycle.
- A CDB result for the head is written at the edge; commit occurs the following cycle at the earliest (1-cycle latency).

Count:
- count_next = count + accept − commit.
- Full with a simultaneous commit: the dispatch is still rejected that cycle and accepted the next.

Operand lookup (combinational):
- Rs_ready_rob = entry[Rs_tag_rob].valid && (entry.ready || (cdb_valid && cdb_tag == Rs_tag_rob)).
- Data is taken from the CDB bypass when the bypass matches, else from the stored data.
- Rt_* is identical.
- An invalid entry gives ready 0, data 0.

Flush:
- Synchronous, highest priority over dispatch, CDB and commit.
- All valid ← 0; head = tail = count = 0.
- No commit is emitted in the flush cycle.

Test Plan:
- Assert reset for 2 cycles, then release → count=0, dispatch_tag=0, rob_full=0, commit_valid=0; async assertion mid-cycle clears immediately.
- Dispatch dests 5, 6, 7 (wr=1) → tags 0, 1, 2 and count=3. Then:
  - CDB tag1 = 0x0000AAAA → no commit.
  - CDB tag0 = 0x00001111 → next cycle commit_valid=1, tag0, dest5, data 0x1111.
  - The following cycle → tag1, dest6, data 0xAAAA; count=1.
- 32 dispatches → rob_full=1, count=32; 33rd dispatch ignored and tail stays 0. Then:
  - Complete tag0; in the commit cycle also dispatch → not accepted.
  - Next cycle dispatch → accepted with tag 0 (wrap); rob_full=1 again.
- Rs_tag_rob=4 (entry 4 valid, not ready) while CDB tag4 = 0xDEADBEEF → Rs_ready_rob=1, Rs_data_rob=0xDEADBEEF the same cycle; after the edge the value is held from storage.
- CDB to unallocated tag 20 → no state change, Rt_tag_rob=20 reads ready 0. Flush with 10 entries (head ready) → commit_valid=0 in that cycle, count=0, next dispatch tag 0.
- Dispatch dest 9 with wr=0, complete it → commit_valid=1, commit_wr=0, commit_tag matches its tag; verify commit_tag/commit_valid clear the matching RST tag when driven into the RST.

Source files
------------

// File: rtl/rob.sv
`default_nettype none
// ============================================================================
// Module      : rob
// Description : 32-entry reorder buffer. Allocates 5-bit tags at dispatch,
//               captures CDB results, serves operand lookups, retires in order.
// Revision    : 1.0 - initial release
// ============================================================================
module rob #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dispatch_valid,
    input  logic [4:0]        dispatch_dest,
    input  logic              dispatch_wr,
    output logic [4:0]        dispatch_tag,
    output logic              rob_full,
    output logic [5:0]        count,
    input  logic              cdb_valid,
    input  logic [4:0]        cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic [4:0]        Rs_tag_rob,
    output logic              Rs_ready_rob,
    output logic [DATA_W-1:0] Rs_data_rob,
    input  logic [4:0]        Rt_tag_rob,
    output logic              Rt_ready_rob,
    output logic [DATA_W-1:0] Rt_data_rob,
    output logic              commit_valid,
    output logic [4:0]        commit_tag,
    output logic [4:0]        commit_dest,
    output logic              commit_wr,
    output logic [DATA_W-1:0] commit_data,
    input  logic              flush
);

    localparam logic [5:0] c_full_count = 6'(DEPTH);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_ready;
    logic [DEPTH-1:0]  r_wr;
    logic [4:0]        r_dest [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [4:0]        r_head;
    logic [4:0]        r_tail;
    logic [5:0]        r_count;

    logic w_accept;
    logic w_commit;
    logic w_cdb_wr;
    logic w_head_valid;
    logic w_rs_hit;
    logic w_rs_byp;
    logic w_rt_hit;
    logic w_rt_byp;

    assign rob_full     = (r_count == c_full_count);
    assign count        = r_count;
    assign dispatch_tag = r_tail;

    // The tail entry is always invalid when not full, so allocation never
    // collides with a CDB write (which requires a valid target).
    assign w_accept     = dispatch_valid && !rob_full;
    assign w_cdb_wr     = cdb_valid && r_valid[cdb_tag];
    assign w_head_valid = r_valid[r_head];
    assign w_commit     = w_head_valid && r_ready[r_head] && !flush;

    assign commit_valid = w_commit;
    assign commit_tag   = w_head_valid ? r_head         : 5'd0;
    assign commit_dest  = w_head_valid ? r_dest[r_head] : 5'd0;
    assign commit_wr    = w_head_valid ? r_wr[r_head]   : 1'b0;
    assign commit_data  = w_head_valid ? r_data[r_head] : '0;

    always_comb begin
        w_rs_hit     = r_valid[Rs_tag_rob];
        w_rs_byp     = cdb_valid && (cdb_tag == Rs_tag_rob);
        Rs_ready_rob = w_rs_hit && (r_ready[Rs_tag_rob] || w_rs_byp);
        Rs_data_rob  = '0;
        if (w_rs_hit)
            Rs_data_rob = w_rs_byp ? cdb_data : r_data[Rs_tag_rob];
    end

    always_comb begin
        w_rt_hit     = r_valid[Rt_tag_rob];
        w_rt_byp     = cdb_valid && (cdb_tag == Rt_tag_rob);
        Rt_ready_rob = w_rt_hit && (r_ready[Rt_tag_rob] || w_rt_byp);
        Rt_data_rob  = '0;
        if (w_rt_hit)
            Rt_data_rob = w_rt_byp ? cdb_data : r_data[Rt_tag_rob];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_ready <= '0;
            r_wr    <= '0;
            r_dest  <= '{default: '0};
            r_data  <= '{default: '0};
            r_head  <= 5'd0;
            r_tail  <= 5'd0;
            r_count <= 6'd0;
        end else if (flush) begin
            r_valid <= '0;
            r_head  <= 5'd0;
            r_tail  <= 5'd0;
            r_count <= 6'd0;
        end else begin
            if (w_cdb_wr) begin
                r_ready[cdb_tag] <= 1'b1;
                r_data[cdb_tag]  <= cdb_data;
            end
            if (w_accept) begin
                r_valid[r_tail] <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_wr[r_tail]    <= dispatch_wr;
                r_dest[r_tail]  <= dispatch_dest;
                r_tail          <= r_tail + 5'd1;
            end
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 5'd1;
            end
            r_count <= r_count + 6'(w_accept) - 6'(w_commit);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rob.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob
// Description : Scoreboard bench for rob; expected commits queued at dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob;

    logic        clock = 1'b0;
    logic        reset;
    logic        dispatch_valid;
    logic [4:0]  dispatch_dest;
    logic        dispatch_wr;
    logic [4:0]  dispatch_tag;
    logic        rob_full;
    logic [5:0]  count;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [4:0]  Rs_tag_rob;
    logic        Rs_ready_rob;
    logic [31:0] Rs_data_rob;
    logic [4:0]  Rt_tag_rob;
    logic        Rt_ready_rob;
    logic [31:0] Rt_data_rob;
    logic        commit_valid;
    logic [4:0]  commit_tag;
    logic [4:0]  commit_dest;
    logic        commit_wr;
    logic [31:0] commit_data;
    logic        flush;

    rob #(.DEPTH(32), .DATA_W(32)) u_dut (
        .clock(clock), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_dest(dispatch_dest),
        .dispatch_wr(dispatch_wr), .dispatch_tag(dispatch_tag),
        .rob_full(rob_full), .count(count),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .Rs_tag_rob(Rs_tag_rob), .Rs_ready_rob(Rs_ready_rob), .Rs_data_rob(Rs_data_rob),
        .Rt_tag_rob(Rt_tag_rob), .Rt_ready_rob(Rt_ready_rob), .Rt_data_rob(Rt_data_rob),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_dest(commit_dest),
        .commit_wr(commit_wr), .commit_data(commit_data), .flush(flush)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] tag;
        logic [4:0] dest;
        logic       wr;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb[$];
    logic [31:0] model_data [32];
    logic [4:0]  exp_tail;
    logic        rst_busy [32];
    logic [4:0]  rst_tag  [32];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Commit monitor: every retirement must match the oldest queued dispatch.
    always @(negedge clock) begin
        exp_t e;
        if (commit_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_commit", 32'(commit_tag), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("commit_tag",  32'(commit_tag),  32'(e.tag));
                check("commit_dest", 32'(commit_dest), 32'(e.dest));
                check("commit_wr",   32'(commit_wr),   32'(e.wr));
                check("commit_data", commit_data,      model_data[e.tag]);
            end
        end
    end

    // Minimal register status table driven by the ROB's tag outputs.
    always @(posedge clock) begin
        if (reset === 1'b0) begin
            if (commit_valid === 1'b1)
                for (int r = 0; r < 32; r++)
                    if (rst_busy[r] && rst_tag[r] == commit_tag) rst_busy[r] = 1'b0;
            if (dispatch_valid && !rob_full && dispatch_wr) begin
                rst_busy[dispatch_dest] = 1'b1;
                rst_tag[dispatch_dest]  = dispatch_tag;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic dispatch(input logic [4:0] dest, input logic wr);
        dispatch_valid = 1'b1;
        dispatch_dest  = dest;
        dispatch_wr    = wr;
        #1;
        check("dispatch_tag", 32'(dispatch_tag), 32'(exp_tail));
        sb.push_back('{tag: exp_tail, dest: dest, wr: wr});
        tick();
        exp_tail       = exp_tail + 5'd1;
        dispatch_valid = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] tag, input logic [31:0] data);
        cdb_valid       = 1'b1;
        cdb_tag         = tag;
        cdb_data        = data;
        model_data[tag] = data;
        tick();
        cdb_valid       = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        #1;
        check("flush_no_commit", 32'(commit_valid), 32'd0);
        tick();
        flush = 1'b0;
        sb.delete();
        exp_tail = 5'd0;
        #1;
        check("flush_count", 32'(count), 32'd0);
        check("flush_tag",   32'(dispatch_tag), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0;
        dispatch_valid = 1'b0; dispatch_dest = 5'd0; dispatch_wr = 1'b0;
        cdb_valid = 1'b0; cdb_tag = 5'd0; cdb_data = 32'd0;
        Rs_tag_rob = 5'd0; Rt_tag_rob = 5'd0;
        exp_tail = 5'd0;
        for (int i = 0; i < 32; i++) begin
            model_data[i] = 32'd0; rst_busy[i] = 1'b0; rst_tag[i] = 5'd0;
        end

        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_count",  32'(count), 32'd0);
        check("rst_tag",    32'(dispatch_tag), 32'd0);
        check("rst_full",   32'(rob_full), 32'd0);
        check("rst_commit", 32'(commit_valid), 32'd0);
        check("rst_cdata",  commit_data, 32'd0);

        // In-order retirement with out-of-order completion
        dispatch(5'd5, 1'b1); dispatch(5'd6, 1'b1); dispatch(5'd7, 1'b1);
        #1 check("count3", 32'(count), 32'd3);
        cdb(5'd1, 32'h0000_AAAA);
        #1 check("no_commit_head_busy", 32'(commit_valid), 32'd0);
        cdb(5'd0, 32'h0000_1111);
        #1;
        check("c0_valid", 32'(commit_valid), 32'd1);
        check("c0_tag",   32'(commit_tag), 32'd0);
        check("c0_dest",  32'(commit_dest), 32'd5);
        check("c0_data",  commit_data, 32'h0000_1111);
        tick();
        check("c1_valid", 32'(commit_valid), 32'd1);
        check("c1_tag",   32'(commit_tag), 32'd1);
        check("c1_dest",  32'(commit_dest), 32'd6);
        check("c1_data",  commit_data, 32'h0000_AAAA);
        tick();
        check("count1", 32'(count), 32'd1);
        check("c2_wait", 32'(commit_valid), 32'd0);
        do_flush();

        // Fill, reject when full, wrap
        for (int i = 0; i < 32; i++) dispatch(5'(i), 1'b1);
        #1;
        check("full",       32'(rob_full), 32'd1);
        check("full_count", 32'(count), 32'd32);
        check("full_tag",   32'(dispatch_tag), 32'd0);
        dispatch_valid = 1'b1; dispatch_dest = 5'd3; dispatch_wr = 1'b1;
        tick();
        dispatch_valid = 1'b0;
        #1;
        check("rej_count", 32'(count), 32'd32);
        check("rej_tail",  32'(dispatch_tag), 32'd0);
        cdb(5'd0, 32'h0000_0100);
        dispatch_valid = 1'b1; dispatch_dest = 5'd17; dispatch_wr = 1'b1;
        #1;
        check("fc_commit", 32'(commit_valid), 32'd1);
        check("fc_full",   32'(rob_full), 32'd1);
        tick();
        dispatch_valid = 1'b0;
        #1;
        check("fc_count", 32'(count), 32'd31);
        check("fc_tail",  32'(dispatch_tag), 32'd0);
        check("fc_nfull", 32'(rob_full), 32'd0);
        dispatch(5'd30, 1'b1);
        #1;
        check("wrap_full",  32'(rob_full), 32'd1);
        check("wrap_count", 32'(count), 32'd32);

        // Operand lookup with CDB bypass, then from storage
        Rs_tag_rob = 5'd4; Rt_tag_rob = 5'd5;
        cdb_valid = 1'b1; cdb_tag = 5'd4; cdb_data = 32'hDEAD_BEEF;
        model_data[4] = 32'hDEAD_BEEF;
        #1;
        check("rs_byp_ready", 32'(Rs_ready_rob), 32'd1);
        check("rs_byp_data",  Rs_data_rob, 32'hDEAD_BEEF);
        check("rt_busy",      32'(Rt_ready_rob), 32'd0);
        tick();
        cdb_valid = 1'b0;
        #1;
        check("rs_st_ready", 32'(Rs_ready_rob), 32'd1);
        check("rs_st_data",  Rs_data_rob, 32'hDEAD_BEEF);
        do_flush();

        // Broadcast to an unallocated tag, then flush with a ready head
        for (int i = 0; i < 10; i++) dispatch(5'(i + 1), 1'b1);
        Rt_tag_rob = 5'd20;
        cdb_valid = 1'b1; cdb_tag = 5'd20; cdb_data = 32'h0000_0055;
        #1;
        check("t20_ready", 32'(Rt_ready_rob), 32'd0);
        check("t20_data",  Rt_data_rob, 32'd0);
        tick();
        cdb_valid = 1'b0;
        #1;
        check("t20_after", 32'(Rt_ready_rob), 32'd0);
        check("t20_count", 32'(count), 32'd10);
        cdb(5'd0, 32'h0000_1234);
        do_flush();
        check("post_flush_commit", 32'(commit_valid), 32'd0);

        // Non-writing instruction and RST tag clear
        dispatch(5'd9, 1'b0);
        dispatch(5'd12, 1'b1);
        #1 check("rst12_busy", 32'(rst_busy[12]), 32'd1);
        cdb(5'd0, 32'h0000_0077);
        #1;
        check("nw_valid", 32'(commit_valid), 32'd1);
        check("nw_wr",    32'(commit_wr), 32'd0);
        check("nw_tag",   32'(commit_tag), 32'd0);
        check("nw_dest",  32'(commit_dest), 32'd9);
        tick();
        cdb(5'd1, 32'h0000_0088);
        tick();
        check("rst12_clear", 32'(rst_busy[12]), 32'd0);
        check("drain_count", 32'(count), 32'd0);

        // Asynchronous reset mid-cycle with a commit pending
        dispatch(5'd1, 1'b1);
        cdb(5'd0, 32'h0000_0099);
        #2 reset = 1'b1;
        #1;
        check("areset_commit", 32'(commit_valid), 32'd0);
        check("areset_count",  32'(count), 32'd0);
        check("areset_tag",    32'(dispatch_tag), 32'd0);
        tick();
        reset = 1'b0;
        sb.delete();
        exp_tail = 5'd0;
        tick();
        check("areset_hold", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
